// File: rtl/text_stream_reader_pkg.sv
// text_stream_reader_pkg: shared character constants and reader FSM state encoding
package text_stream_reader_pkg;
   localparam logic [7:0] TILDE = 8'h7E;
   localparam logic [7:0] SPACE = 8'h20;
   localparam logic [7:0] CR    = 8'h0D;
   localparam logic [7:0] LF    = 8'h0A;
   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_SEND, S_CR, S_LF, S_DONE
   } state_e;
endpackage

// File: rtl/text_stream_reader.sv
// text_stream_reader: walks a window of the 128x8 char buffer and streams bytes over valid/ready
module text_stream_reader
   import text_stream_reader_pkg::*;
#(
   parameter int BASE      = 0,
   parameter int LEN       = 32,
   parameter int LINE_LEN  = 16,
   parameter int EOL_EN    = 1,
   parameter int BLANK_SUB = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   output logic [7:0] addr,
   input  logic [7:0] rdata,
   output logic       rd_own,
   output logic [7:0] tx_data,
   output logic       tx_valid,
   input  logic       tx_ready,
   output logic       busy,
   output logic       done
);
   localparam logic [6:0] BASE_A = 7'(BASE);
   localparam logic [7:0] LEN_W  = 8'(LEN);
   localparam logic [7:0] LINE_W = 8'(LINE_LEN);

   state_e     state_q, state_d;
   logic [6:0] addr_q, addr_d;
   logic [7:0] cnt_q, cnt_d, col_q, col_d, tx_data_q, tx_data_d;
   logic       tx_valid_q, tx_valid_d, busy_q, busy_d, hs;

   function automatic logic [7:0] blank_sub(input logic [7:0] c);
      return (BLANK_SUB != 0 && c == TILDE) ? SPACE : c;
   endfunction

   assign hs       = tx_valid_q & tx_ready;
   assign addr     = {1'b0, addr_q};
   assign tx_data  = tx_data_q;
   assign tx_valid = tx_valid_q;
   assign busy     = busy_q;
   assign rd_own   = busy_q;
   assign done     = state_q == S_DONE;

   // next-state: fetch a cell, hold it until accepted, then optional CR/LF, then advance
   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      cnt_d      = cnt_q;
      col_d      = col_q;
      tx_data_d  = tx_data_q;
      tx_valid_d = tx_valid_q;
      busy_d     = busy_q;
      case (state_q)
         S_IDLE: if (start) begin
            addr_d  = BASE_A;
            cnt_d   = '0;
            col_d   = '0;
            busy_d  = 1'b1;
            state_d = S_FETCH;
         end
         S_FETCH: begin
            tx_data_d  = blank_sub(rdata);
            tx_valid_d = 1'b1;
            state_d    = S_SEND;
         end
         S_SEND: if (hs) begin
            cnt_d = cnt_q + 8'd1;
            col_d = col_q + 8'd1;
            if (EOL_EN != 0 && col_q + 8'd1 == LINE_W) begin
               tx_data_d = CR;
               state_d   = S_CR;
            end else begin
               tx_valid_d = 1'b0;
               addr_d     = (cnt_q + 8'd1 == LEN_W) ? addr_q : addr_q + 7'd1;
               state_d    = (cnt_q + 8'd1 == LEN_W) ? S_DONE : S_FETCH;
            end
         end
         S_CR: if (hs) begin
            tx_data_d = LF;
            state_d   = S_LF;
         end
         S_LF: if (hs) begin
            col_d      = '0;
            tx_valid_d = 1'b0;
            addr_d     = (cnt_q == LEN_W) ? addr_q : addr_q + 7'd1;
            state_d    = (cnt_q == LEN_W) ? S_DONE : S_FETCH;
         end
         S_DONE: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // state register with synchronous reset that aborts any pass in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         addr_q     <= BASE_A;
         cnt_q      <= '0;
         col_q      <= '0;
         tx_data_q  <= '0;
         tx_valid_q <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         cnt_q      <= cnt_d;
         col_q      <= col_d;
         tx_data_q  <= tx_data_d;
         tx_valid_q <= tx_valid_d;
         busy_q     <= busy_d;
      end
   end
endmodule

// File: tb/tb_text_stream_reader.sv
// tb_text_stream_reader: scoreboard bench over four reader configurations sharing one buffer model
module tb_text_stream_reader;
   typedef struct {
      logic [7:0] d;
      int         t;
      int         a;
   } exp_t;

   logic       clk = 1'b0, rst = 1'b1, tx_ready = 1'b1;
   logic       start [4];
   logic [7:0] addr_w [4], rdata_w [4], tx_data_w [4];
   logic       rd_own_w [4], tx_valid_w [4], busy_w [4], done_w [4];
   logic [7:0] mem [128];
   exp_t       exp_q [$];
   exp_t       m_e;
   int         errors = 0, checks = 0, cyc = 0, t0 = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      assign rdata_w[g] = mem[addr_w[g][6:0]];
      text_stream_reader #(
         .BASE(g == 3 ? 126 : 0), .LEN(g == 1 ? 2 : 4), .LINE_LEN(g == 2 ? 2 : 16),
         .EOL_EN(g == 2 ? 1 : 0), .BLANK_SUB(g == 1 ? 0 : 1)
      ) u_dut (
         .clk(clk), .rst(rst), .start(start[g]), .addr(addr_w[g]), .rdata(rdata_w[g]),
         .rd_own(rd_own_w[g]), .tx_data(tx_data_w[g]), .tx_valid(tx_valid_w[g]),
         .tx_ready(tx_ready), .busy(busy_w[g]), .done(done_w[g])
      );
   end

   task automatic check(input bit ok, input string name, input int act, input int req);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got %0h required %0h", name, act, req);
      end
   endtask

   // monitor: every accepted byte is popped from the scoreboard and compared
   always @(negedge clk) begin
      for (int g = 0; g < 4; g++) begin
         if (tx_valid_w[g] && tx_ready) begin
            if (exp_q.size() == 0) begin
               check(0, $sformatf("unexpected_byte dut%0d", g), int'(tx_data_w[g]), 0);
            end else begin
               m_e = exp_q.pop_front();
               check(tx_data_w[g] === m_e.d, $sformatf("tx_data dut%0d", g), int'(tx_data_w[g]), int'(m_e.d));
               if (m_e.t >= 0) check(cyc - t0 + 1 == m_e.t, $sformatf("hs_cycle dut%0d", g), cyc - t0 + 1, m_e.t);
               if (m_e.a >= 0) check(addr_w[g] === 8'(m_e.a), $sformatf("addr dut%0d", g), int'(addr_w[g]), m_e.a);
            end
         end
      end
   end

   task automatic push(input int d, input int t, input int a);
      exp_t e;
      e.d = 8'(d);
      e.t = t;
      e.a = a;
      exp_q.push_back(e);
   endtask

   task automatic start_pass(input int g);
      @(negedge clk);
      start[g] = 1'b1;
      @(posedge clk);
      #1;
      t0 = cyc;
      start[g] = 1'b0;
   endtask

   task automatic wait_done(input int g, input bit restart);
      int nd = 0, extra = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (done_w[g]) nd++;
         start[g] = restart && done_w[g];
         if (!busy_w[g] && !done_w[g] && nd > 0) break;
      end
      start[g] = 1'b0;
      check(nd == 1, $sformatf("done_pulses dut%0d", g), nd, 1);
      check(!busy_w[g], $sformatf("busy_after dut%0d", g), int'(busy_w[g]), 0);
      check(exp_q.size() == 0, $sformatf("bytes_missing dut%0d", g), exp_q.size(), 0);
      exp_q.delete();
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (done_w[g] || tx_valid_w[g] || busy_w[g]) extra++;
      end
      check(extra == 0, $sformatf("activity_after_done dut%0d", g), extra, 0);
   endtask

   initial begin
      int bad;
      for (int i = 0; i < 128; i++) mem[i] = 8'h7E;
      for (int g = 0; g < 4; g++) start[g] = 1'b0;
      repeat (3) @(negedge clk);
      for (int g = 0; g < 4; g++) begin
         check(addr_w[g] === (g == 3 ? 8'd126 : 8'd0), $sformatf("rst_addr dut%0d", g), int'(addr_w[g]), g == 3 ? 126 : 0);
         check(tx_data_w[g] === 8'h00 && !tx_valid_w[g] && !busy_w[g] && !done_w[g] && !rd_own_w[g],
               $sformatf("rst_outputs dut%0d", g), int'({tx_data_w[g], tx_valid_w[g], busy_w[g], done_w[g]}), 0);
      end
      @(posedge clk);
      #1 rst = 1'b0;

      // blank cells shown as space, handshakes every second cycle
      for (int i = 0; i < 4; i++) push(8'h20, 2 + 2 * i, i);
      start_pass(0);
      wait_done(0, 0);

      // raw bytes without blank substitution
      mem[0] = 8'h48;
      mem[1] = 8'h49;
      push(8'h48, 2, 0);
      push(8'h49, 4, 1);
      start_pass(1);
      wait_done(1, 0);

      // CR/LF after every two characters
      mem[0] = 8'h41; mem[1] = 8'h42; mem[2] = 8'h43; mem[3] = 8'h44;
      push(8'h41, 2, 0);  push(8'h42, 4, 1);  push(8'h0D, 5, -1); push(8'h0A, 6, -1);
      push(8'h43, 8, 2);  push(8'h44, 10, 3); push(8'h0D, 11, -1); push(8'h0A, 12, -1);
      start_pass(2);
      wait_done(2, 0);

      // backpressure on the second byte for five cycles
      for (int i = 0; i < 4; i++) push(8'h41 + i, -1, i);
      start_pass(0);
      @(posedge clk);
      @(posedge clk);
      #1 tx_ready = 1'b0;
      @(posedge clk);
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (!tx_valid_w[0] || tx_data_w[0] !== 8'h42 || addr_w[0] !== 8'd1) bad++;
      end
      check(bad == 0, "stall_hold", bad, 0);
      @(posedge clk);
      #1 tx_ready = 1'b1;
      wait_done(0, 0);

      // address wrap from 126 through 0
      mem[126] = 8'h52;
      mem[127] = 8'h53;
      push(8'h52, 2, 126); push(8'h53, 4, 127); push(8'h41, 6, 0); push(8'h42, 8, 1);
      start_pass(3);
      wait_done(3, 0);

      // start while busy and start coincident with done are both ignored
      for (int i = 0; i < 4; i++) push(8'h41 + i, 2 + 2 * i, i);
      start_pass(0);
      repeat (2) @(negedge clk);
      start[0] = 1'b1;
      @(negedge clk);
      start[0] = 1'b0;
      wait_done(0, 1);

      // reset while a byte is pending aborts the pass silently
      @(posedge clk);
      #1 tx_ready = 1'b0;
      start_pass(0);
      @(posedge clk);
      #1;
      check(tx_valid_w[0] && busy_w[0], "pre_rst_send", int'({tx_valid_w[0], busy_w[0]}), 3);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      check(!tx_valid_w[0] && !busy_w[0] && !done_w[0], "rst_abort", int'({tx_valid_w[0], busy_w[0], done_w[0]}), 0);
      check(addr_w[0] === 8'd0, "rst_abort_addr", int'(addr_w[0]), 0);
      bad = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (done_w[0] || tx_valid_w[0] || busy_w[0]) bad++;
      end
      check(bad == 0, "no_done_after_rst", bad, 0);
      @(posedge clk);
      #1 tx_ready = 1'b1;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/text_stream_reader.md
Name: text_stream_reader

Overview:
- Read-side companion of the 128x8 character buffer.
- On a start pulse it walks a window of buffer addresses and reads each byte through the buffer's combinational read port.
- It streams the bytes out over a valid/ready byte interface to the downstream character sink (UART TX / LCD writer).
- Blank cells (TILDE) are optionally shown as SPACE, and CR/LF is optionally inserted at each line end.

Parameters:
BASE, 0, first buffer address read (0..127)
LEN, 32, number of buffer cells read per pass (1..128)
LINE_LEN, 16, characters per line before CR/LF insertion (1..128)
EOL_EN, 1, 1 = insert CR (0x0D), LF (0x0A) after every LINE_LEN characters
BLANK_SUB, 1, 1 = output TILDE (0x7E) as SPACE (0x20)

Ports:
clk  in  1  system clock, all logic on posedge
rst  in  1  synchronous active-high reset
start  in  1  single-cycle request to begin a pass; ignored unless idle
addr  out  8  buffer read address; MSB always 0
rdata  in  8  buffer read data (combinational from addr)
rd_own  out  1  high while block needs addr routed to buffer (= busy)
tx_data  out  8  output character
tx_valid  out  1  tx_data valid
tx_ready  in  1  sink accepts tx_data this cycle
busy  out  1  pass in progress
done  out  1  one-cycle pulse at end of pass

Behaviour:
- Reset values: state IDLE, addr=BASE, tx_data=0x00, tx_valid=0, busy=0, done=0, char count=0, column=0.
- Reset mid-pass aborts the pass; tx_valid is 0 after that edge and no done pulse is issued.
- States: IDLE, FETCH, SEND, CR, LF, DONE.
- IDLE: start=1 -> addr<=BASE, cnt<=0, col<=0, busy<=1, go to FETCH.
- FETCH (1 cycle):
  - addr is stable.
  - tx_data <= rdata, or 0x20 if BLANK_SUB and rdata==0x7E.
  - tx_valid<=1; go to SEND.
- SEND:
  - tx_data and tx_valid are held stable until tx_ready=1.
  - On handshake (tx_valid & tx_ready): cnt++, col++.
  - If EOL_EN and col+1==LINE_LEN: go to CR.
  - Else if cnt+1==LEN: tx_valid<=0, go to DONE.
  - Else addr<=(addr+1) mod 128, tx_valid<=0, go to FETCH.
- CR: tx_data=0x0D, valid held until handshake, then go to LF.
- LF: tx_data=0x0A, valid held until handshake, then col<=0.
  - If this was the last character, go to DONE.
  - Else addr++ mod 128 and go to FETCH.
- DONE: done=1 for exactly one cycle, busy<=0, go to IDLE.
- Latency:
  - First tx_valid rises 2 cycles after start is sampled.
  - Minimum 2 cycles per buffer character with tx_ready tied high.
  - 1 cycle each for CR and LF.
- Address wrap: address = (BASE+cnt) mod 128; addr[7]=0 always.
- start while busy: no effect.
- start in the same cycle as the done pulse: ignored; the next start is accepted from IDLE.
- tx_valid never drops without a handshake, except on rst.
- Buffer writes to a cell already sent are not re-read.
- A write in the FETCH cycle of the same cell follows the buffer's read-during-write behaviour (old data).
- Arbitration between the buffer's write path and this block's addr uses rd_own and lives outside this block.

Decomposition:
- Shared constants header (the one already defining TILDE) also gets SPACE=0x20, CR=0x0D, LF=0x0A and the state encodings.
- No sub-module: the count/column counters and the FSM sit in one module (~150-200 lines).
- Blank substitution is a local function.

Test Plan:
- After buffer rst (all 0x7E): BASE=0, LEN=4, EOL_EN=0, tx_ready=1, pulse start.
  - Required: tx bytes 0x20 x4 on cycles 2,4,6,8 after start.
  - Required: done pulse once; busy low afterwards.
- Write 'H'=0x48 to addr 0 and 'I'=0x49 to addr 1, then LEN=2, BLANK_SUB=0 -> 0x48, 0x49, done.
- LINE_LEN=2, LEN=4, EOL_EN=1, cells 'A','B','C','D' -> 0x41 0x42 0x0D 0x0A 0x43 0x44 0x0D 0x0A, then done.
- tx_ready low 5 cycles while second byte is pending:
  - tx_valid=1, tx_data and addr unchanged throughout.
  - Byte count is correct after release.
- BASE=126, LEN=4 -> addr sequence 126, 127, 0, 1; addr[7]=0 throughout.
- start pulsed while busy -> ignored, single done. Then rst asserted in SEND -> next cycle tx_valid=0, busy=0, no done, addr=BASE.
